div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divide/remainder unit for the execute stage. Computes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle, under a start/busy/done handshake. Its `result` is the divide-path input of the execute-stage result-select 2:1 mux, which forwards it to writeback. The control unit stalls the pipeline while `busy` is high.

## Interface
- `N`, default 32: operand and result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only when accepted (see Operation).
- `kill`  in  1  pipeline flush; aborts the operation in flight.
- `op`  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `A`  in  N  dividend.
- `B`  in  N  divisor.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse marking the cycle in which `result` becomes valid.
- `result`  out  N  quotient or remainder; holds its value until the next accepted start.

## Operation
- **States:** IDLE, CALC, DONE.
- **Reset:** state IDLE; `busy`=0, `done`=0, `result`=0; internal counter and registers cleared.
- **Start acceptance:** `start` is accepted in IDLE or DONE. It is ignored in CALC.
- **On acceptance:** latch `A`, `B` and `op`. Later changes on `A`, `B` or `op` have no effect.
- **Special cases** (checked at acceptance; go directly to DONE and skip CALC):
  - Divide by zero (`B`=0): quotient = all ones; remainder = `A`.
  - Signed overflow (DIV/REM, `A`=100…0, `B`=all ones): quotient = `A`; remainder = 0.
- **Normal path:** go to CALC with counter = N.
  - Signed ops use the magnitudes |A| and |B|. The most-negative value is treated as the unsigned 2^(N-1).
- **CALC, each cycle:**
  - Shift {rem, quo} left by one, bringing in the next dividend bit.
  - Trial-subtract the divisor from rem using an N+1-bit subtractor.
  - If the result is non-negative, keep the difference and set the new quotient bit to 1.
  - Decrement the counter. After N iterations, go to DONE.
- **Sign fix-up** (applied when entering DONE):
  - DIV: the quotient is negated when the operand signs differ.
  - REM: the remainder takes the sign of the dividend.
  - Unsigned ops skip fix-up.
- **DONE:** lasts one cycle; `result` is loaded and `done`=1.
  - Without `start`, the next state is IDLE.
  - With `start`, a new operation is accepted (back-to-back).
- **kill:**
  - In CALC: next state is IDLE; `busy`=0; `done` is never asserted; `result` keeps its previous value.
  - In IDLE or DONE: cancels a coincident `start`.
  - kill has priority over start.
- **rst:** has priority over everything, including mid-CALC.
- **Width rules:** all arithmetic is modulo 2^N. Only the trial subtractor carries an extra bit.

## Timing
- `start` accepted at edge k, normal path:
  - `busy`=1 during cycles k+1 … k+N+1.
  - `done`=1 and `result` valid at cycle k+N+1. Latency is N+1 cycles (33 for N=32).
- `start` accepted at edge k, special case:
  - `busy`=1 and `done`=1 at cycle k+1. Latency is 1 cycle.
- `busy` is high in both CALC and DONE and low in IDLE.
- `result` updates only on entry to DONE and is otherwise stable.
- Back-to-back operation: with `start` asserted during DONE at edge j, the next operation's `busy` stays high continuously and its `done` follows at j+N+1.

## Test plan
- **DIVU then REMU:** DIVU `A`=100, `B`=7, start at k → `done` at k+33 with `result`=14. Repeat with REMU → `result`=2.
- **Signed rounding and sign rules:**
  - DIV `A`=−7 (0xFFFFFFF9), `B`=2 → 0xFFFFFFFD (−3).
  - REM, same operands → 0xFFFFFFFF (−1).
  - REM `A`=7, `B`=−2 → 1.
- **Divide by zero:**
  - DIVU `A`=5, `B`=0 → `done` at k+1 with 0xFFFFFFFF.
  - REMU, same operands → 5.
  - DIV `A`=−5, `B`=0 → 0xFFFFFFFF.
- **Signed overflow:**
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at k+1.
  - REM, same operands → 0.
- **kill mid-operation:**
  - `kill` 10 cycles after start → `busy`=0 the next cycle, no `done` pulse, `result` unchanged.
  - A new start (DIVU 9/3) then yields 3 at +33.
- **Reset, ignored start and back-to-back:**
  - `rst` mid-CALC → all outputs 0 the next cycle.
  - `start` with different operands during CALC is ignored; the original result is delivered.
  - `start` held during DONE → second `done` exactly 33 cycles later with `busy` never dropping.

Source files
------------

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division that produces one quotient bit per cycle.
// Uses a start/busy/done handshake. Division by zero and signed overflow
// are resolved as soon as the operation is accepted, so they finish in one cycle.
module div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         kill,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    // rem_reg holds the partial remainder.
    // quo_reg starts as the dividend magnitude; quotient bits are shifted in from the right.
    logic [N-1:0] rem_reg, rem_next;
    logic [N-1:0] quo_reg, quo_next;
    logic [N-1:0] dvs_reg, dvs_next;
    logic [N-1:0] result_reg, result_next;
    logic         sel_rem_reg, sel_rem_next;
    logic         neg_q_reg, neg_q_next;
    logic         neg_r_reg, neg_r_next;

    // ------------------------------------------------------------------
    // Operand preparation, evaluated on the raw inputs at acceptance.
    // ------------------------------------------------------------------
    logic [N-1:0] min_neg;
    logic         is_signed;
    logic         sign_a;
    logic         sign_b;
    logic         b_zero;
    logic         overflow;
    logic [N-1:0] mag_a;
    logic [N-1:0] mag_b;

    // The most negative N-bit value (1 followed by zeros), built bit by bit.
    for (genvar gi = 0; gi < N; gi++) begin : g_min_neg
        assign min_neg[gi] = (gi == N - 1);
    end

    // Magnitude conversion; the most negative value maps to unsigned 2^(N-1).
    always_comb begin
        is_signed = ~op[0];
        sign_a    = is_signed & A[N-1];
        sign_b    = is_signed & B[N-1];
        mag_a     = sign_a ? (N'(0) - A) : A;
        mag_b     = sign_b ? (N'(0) - B) : B;
        b_zero    = (B == '0);
        overflow  = is_signed & (A == min_neg) & (&B);
    end

    // ------------------------------------------------------------------
    // One restoring-division step.
    // ------------------------------------------------------------------
    logic [N:0]   shift_val;
    logic [N:0]   trial_diff;
    logic         q_bit;
    logic [N-1:0] step_rem;
    logic [N-1:0] step_quo;
    logic [N-1:0] fix_quo;
    logic [N-1:0] fix_rem;

    // Shift in the next dividend bit, then do an (N+1)-bit trial subtraction.
    // The sign bit of the difference decides whether to keep it (restoring step).
    // The remainder is always below the divisor, so the shifted value is below
    // twice the divisor. The difference therefore always fits in N+1 signed bits.
    always_comb begin
        shift_val  = {rem_reg, quo_reg[N-1]};
        trial_diff = shift_val - {1'b0, dvs_reg};
        q_bit      = ~trial_diff[N];
        step_rem   = q_bit ? trial_diff[N-1:0] : shift_val[N-1:0];
        step_quo   = {quo_reg[N-2:0], q_bit};
        fix_quo    = neg_q_reg ? (N'(0) - step_quo) : step_quo;
        fix_rem    = neg_r_reg ? (N'(0) - step_rem) : step_rem;
    end

    // ------------------------------------------------------------------
    // Control: next-state and datapath-next logic.
    // ------------------------------------------------------------------
    logic accept;

    // Accept or reject start, run iterations, and apply sign fix-up on the final step.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        dvs_next     = dvs_reg;
        result_next  = result_reg;
        sel_rem_next = sel_rem_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        // kill cancels a coincident start; start is ignored while in CALC.
        accept       = start & ~kill & (state_reg != CALC);

        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
                    sel_rem_next = op[1];
                    if (b_zero) begin
                        state_next  = DONE;
                        result_next = op[1] ? A : '1;
                    end else if (overflow) begin
                        state_next  = DONE;
                        result_next = op[1] ? '0 : A;
                    end else begin
                        state_next = CALC;
                        cnt_next   = CNT_W'(N);
                        rem_next   = '0;
                        quo_next   = mag_a;
                        dvs_next   = mag_b;
                        neg_q_next = sign_a ^ sign_b;
                        neg_r_next = sign_a;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    // Abandon the operation; result keeps its previous value.
                    state_next = IDLE;
                end else begin
                    rem_next = step_rem;
                    quo_next = step_quo;
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next  = DONE;
                        result_next = sel_rem_reg ? fix_rem : fix_quo;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register all state; reset overrides everything, including an operation in CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            result_reg  <= '0;
            sel_rem_reg <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            dvs_reg     <= dvs_next;
            result_reg  <= result_next;
            sel_rem_reg <= sel_rem_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
        end
    end

    // Outputs are decoded directly from registered state.
    always_comb begin
        busy   = (state_reg != IDLE);
        done   = (state_reg == DONE);
        result = result_reg;
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// A table of vectors is driven in sequence; each expected result and its
// arrival cycle are pushed to a scoreboard queue. A monitor pops and compares
// an entry whenever done is seen.
// Hand-written sequences cover kill, reset, ignored start and back-to-back.
module tb_div_unit;

    localparam int N = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         kill;
    logic [1:0]   op;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    div_unit #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .A      (a_in),
        .B      (b_in),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] res;
        int           cyc;
    } exp_t;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
        int           lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[20];
    int   ncyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=0x%08h at cycle %0d, required no done", result, ncyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_cycle"}, ncyc, e.cyc);
                check({e.name, "_busy"}, {31'd0, busy}, 32'd1);
                $display("txn %s: result=0x%08h at cycle %0d", e.name, result, ncyc);
            end
        end
    end

    // Drive one start pulse from a negedge. Optionally push the expected
    // outcome to the scoreboard. Afterwards scramble the operands, which the
    // DUT must ignore once it has latched them.
    task automatic drive(input string name, input logic [1:0] o, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] exp, input int lat,
                         input bit expect_it);
        exp_t e;
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        if (expect_it) begin
            e.name = name;
            e.res  = exp;
            e.cyc  = ncyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 60) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bit drop;
        bit found;

        vecs[0]  = '{"divu_100_7",      OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{"remu_100_7",      OP_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{"div_m7_2",        OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
        vecs[3]  = '{"rem_m7_2",        OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
        vecs[4]  = '{"rem_7_m2",        OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          33};
        vecs[5]  = '{"div_7_m2",        OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33};
        vecs[6]  = '{"divu_5_0",        OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
        vecs[7]  = '{"remu_5_0",        OP_REMU, 32'd5,          32'd0,          32'd5,          1};
        vecs[8]  = '{"div_m5_0",        OP_DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1};
        vecs[9]  = '{"rem_m5_0",        OP_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1};
        vecs[10] = '{"div_ovf",         OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
        vecs[11] = '{"rem_ovf",         OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
        vecs[12] = '{"divu_min_ones",   OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33};
        vecs[13] = '{"remu_min_ones",   OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33};
        vecs[14] = '{"div_min_2",       OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   33};
        vecs[15] = '{"div_min_1",       OP_DIV,  32'h80000000,   32'd1,          32'h80000000,   33};
        vecs[16] = '{"remu_max_16",     OP_REMU, 32'hFFFFFFFF,   32'd16,         32'd15,         33};
        vecs[17] = '{"div_m100_m7",     OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33};
        vecs[18] = '{"rem_m100_7",      OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   33};
        vecs[19] = '{"divu_max_1",      OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};

        rst   = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);
            wait_drain(vecs[i].name);
        end

        // A start with different operands during CALC must be ignored.
        drive("ignored_start", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = OP_REMU;
        a_in  = 32'd1000;
        b_in  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_drain("ignored_start");
        check("ignored_idle_busy", {31'd0, busy}, 32'd0);

        // kill ten cycles after start: no done, and result keeps its previous value (14).
        $display("txn kill_mid_calc: start DIVU 1000/3 then kill");
        drive("killed", OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy",   {31'd0, busy}, 32'd0);
        check("kill_done",   {31'd0, done}, 32'd0);
        check("kill_result", result,        32'd14);
        repeat (40) @(negedge clk);
        check("kill_later_busy", {31'd0, busy}, 32'd0);
        drive("divu_9_3_after_kill", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);
        wait_drain("divu_9_3_after_kill");

        // kill cancels a coincident start in IDLE.
        $display("txn kill_start_idle: start and kill together");
        start = 1'b1;
        kill  = 1'b1;
        op    = OP_DIVU;
        a_in  = 32'd9;
        b_in  = 32'd0;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        check("kill_idle_busy", {31'd0, busy}, 32'd0);
        check("kill_idle_done", {31'd0, done}, 32'd0);

        // kill cancels a coincident start in DONE.
        drive("divu_7_0", OP_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 1, 1'b1);
        start = 1'b1;
        kill  = 1'b1;
        op    = OP_DIVU;
        a_in  = 32'd9;
        b_in  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        check("kill_done_busy", {31'd0, busy}, 32'd0);
        wait_drain("kill_done");

        // Back-to-back: start held in DONE; busy must never drop.
        drop  = 1'b0;
        found = 1'b0;
        drive("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) drop = 1'b1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b_first_done_seen", {31'd0, found}, 32'd1);
        drive("b2b_second", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            if (!busy) drop = 1'b1;
            @(negedge clk);
        end
        check("b2b_busy_continuous", {31'd0, drop}, 32'd0);
        wait_drain("b2b_second");

        // Reset in the middle of CALC clears all outputs.
        $display("txn rst_mid_calc: start DIVU 100/7 then rst");
        drive("reset_victim", OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy",   {31'd0, busy}, 32'd0);
        check("rst_mid_done",   {31'd0, done}, 32'd0);
        check("rst_mid_result", result,        32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_after_busy", {31'd0, busy}, 32'd0);
        drive("div_m7_2_after_rst", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b1);
        wait_drain("div_m7_2_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
